// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown for the game timer: load on play, decrement per second, penalty, pause, expiry pulse.
// Optional warn output enabled by defining COUNTDOWN_WARN_EN.
module bcd_countdown_timer #(
  parameter int unsigned           DIGITS      = 3,
  parameter logic [7:0]            PLAY_CODE   = 8'h10,
  parameter logic [7:0]            PAUSE_CODE  = 8'h40,
  parameter logic [7:0]            WIN_CODE    = 8'h20,
  parameter logic [7:0]            LOSE_CODE   = 8'h30,
  parameter logic [4*DIGITS-1:0]   PENALTY     = 'h010,
  parameter logic [4*DIGITS-1:0]   WARN_THRESH = 'h010
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   init_time,
  input  logic [7:0]            game_state,
  input  logic                  sec_tick,
  input  logic                  penalty,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  running,
  output logic                  expired,
  output logic                  warn
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t         state, state_n;
  logic [W-1:0]   digits_n;
  logic           hit_zero;
  logic           running_n, expired_n;
  logic           win_lose;
  logic [W:0]     pen_diff, tick_diff;
  logic [W-1:0]   pen_val, run_val;

  // Digit-serial BCD subtract; MSB of the result is the final borrow (underflow).
  function automatic logic [W:0] bcd_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         borrow;
    logic [4:0]   d;
    r      = '0;
    borrow = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, borrow};
      if (d[4]) begin
        r[4*i +: 4] = d[3:0] + 4'd10;
        borrow      = 1'b1;
      end else begin
        r[4*i +: 4] = d[3:0];
        borrow      = 1'b0;
      end
    end
    return {borrow, r};
  endfunction

  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] a);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DIGITS; i++)
      r[4*i +: 4] = (a[4*i +: 4] > 4'd9) ? 4'd9 : a[4*i +: 4];
    return r;
  endfunction

  // PENALTY+1 is applied as two saturating steps, which gives the same result as one subtract.
  always_comb begin
    pen_diff  = penalty ? bcd_sub(digits, PENALTY) : {1'b0, digits};
    pen_val   = pen_diff[W] ? '0 : pen_diff[W-1:0];
    tick_diff = bcd_sub(pen_val, ONE);
    run_val   = sec_tick ? (tick_diff[W] ? '0 : tick_diff[W-1:0]) : pen_val;
    win_lose  = (game_state == WIN_CODE) || (game_state == LOSE_CODE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      digits  <= {DIGITS{4'h9}};
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      digits  <= digits_n;
      running <= running_n;
      expired <= expired_n;
    end
  end

  always_comb begin
    state_n  = state;
    digits_n = digits;
    hit_zero = 1'b0;
    unique case (state)
      IDLE: begin
        if (game_state == PLAY_CODE) begin
          digits_n = clamp_bcd(init_time);
          state_n  = RUN;
        end
      end
      RUN: begin
        if (win_lose) begin
          state_n = IDLE;
        end else if ((sec_tick || penalty) && (run_val == '0)) begin
          digits_n = '0;
          state_n  = DONE;
          hit_zero = 1'b1;
        end else if (game_state == PAUSE_CODE) begin
          state_n = HOLD;
        end else begin
          digits_n = run_val;
        end
      end
      HOLD: begin
        if (win_lose) begin
          state_n = IDLE;
        end else if (penalty && (pen_val == '0)) begin
          digits_n = '0;
          state_n  = DONE;
          hit_zero = 1'b1;
        end else begin
          digits_n = pen_val;
          if (game_state == PLAY_CODE) state_n = RUN;
        end
      end
      DONE: begin
        digits_n = '0;
        if (game_state != PLAY_CODE) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    running_n = (state_n == RUN);
    expired_n = hit_zero;
  end

`ifdef COUNTDOWN_WARN_EN
  logic warn_n;

  // Valid BCD orders the same as binary, so a plain compare works.
  always_comb begin
    warn_n = ((state_n == RUN) || (state_n == HOLD)) && (digits_n <= WARN_THRESH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) warn <= 1'b0;
    else       warn <= warn_n;
  end
`else
  assign warn = 1'b0;
`endif

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Parametrised multi-digit BCD countdown for the bomb game timer; next generation of the three-digit countdown.
- Loads a BCD start time when the controller enters the play state, then decrements once per one-second pulse from the one-second timer.
- Supports pause, a penalty subtraction on a wrong defuse action, and a registered expiry pulse to the controller.
- Digit outputs feed the seven-segment decoders directly.

Parameters:
DIGITS, 3, number of BCD digits (1..6)
PLAY_CODE, 8'h10, game_state value meaning "armed/counting"
PAUSE_CODE, 8'h40, game_state value meaning "hold count"
WIN_CODE, 8'h20, game_state value meaning "defused"
LOSE_CODE, 8'h30, game_state value meaning "exploded"
PENALTY, 'h010, BCD seconds subtracted per penalty pulse (4*DIGITS bits)
WARN_THRESH, 'h010, BCD threshold for warn (used only with COUNTDOWN_WARN_EN)

Ports:
clk  input  1  on-board 50 MHz clock
reset  input  1  asynchronous, active-high reset
init_time  input  4*DIGITS  BCD start time; [3:0] is the least-significant (rightmost) digit
game_state  input  8  controller state code
sec_tick  input  1  one-cycle pulse per elapsed second
penalty  input  1  one-cycle pulse: subtract PENALTY
digits  output  4*DIGITS  current BCD value, same digit order as init_time
running  output  1  high in RUN
expired  output  1  one-cycle pulse when the count reaches zero
warn  output  1  value <= WARN_THRESH while RUN or HOLD (optional feature)

Behaviour:
- Reset, asynchronous, any time including mid-count:
  - state=IDLE; every digit=9; running=0, expired=0, warn=0.
- States: IDLE, RUN, HOLD, DONE. All outputs are registered.
- IDLE:
  - game_state==PLAY_CODE -> load init_time into digits, go to RUN. Any digit >9 is clamped to 9.
  - sec_tick and penalty are ignored in the load cycle.
  - Otherwise digits hold their current value (last count, or 9s after reset).
- RUN:
  - sec_tick -> BCD subtract 1 with borrow across all digits.
  - penalty -> subtract PENALTY.
  - Both in the same cycle -> subtract PENALTY+1.
  - All subtraction saturates at 0; no wrap below zero.
- Zero reached (by tick, penalty or both): on the same edge digits=0, state->DONE, expired=1 for exactly one cycle.
- RUN with digits already 0 (init_time==0): on the first sec_tick go to DONE and pulse expired.
- RUN, game_state==PAUSE_CODE -> HOLD.
  - HOLD ignores sec_tick. penalty still applies and can reach zero -> DONE + expired.
  - HOLD, game_state==PLAY_CODE -> RUN.
- RUN/HOLD, game_state==WIN_CODE or LOSE_CODE -> IDLE with digits frozen at their current value, for score display.
- Any other game_state code in RUN/HOLD -> no state change.
- DONE: digits=0; exits to IDLE when game_state!=PLAY_CODE. No reload while game_state stays PLAY_CODE.
- Priority within one cycle: reset > WIN/LOSE > zero detection > PAUSE > tick/penalty.
- running=1 only in RUN. expired is never asserted in IDLE or on load.

Optional Feature:
COUNTDOWN_WARN_EN
- Defined: warn is registered and asserted while in RUN or HOLD and digits <= WARN_THRESH (BCD compare); cleared in IDLE/DONE and on reset. Drives the fast-blink buzzer.
- Undefined: warn is tied to 0 and no comparator logic is built.

Test Plan:
- DIGITS=3, reset, game_state=8'h10, init_time=12'h105 -> digits=105 after one clk. 6 sec_ticks -> 104,103,102,101,100,099 (borrow across two digits).
- init_time=12'h002, run 2 ticks -> digits 001 then 000; expired high exactly one cycle; state DONE; further ticks keep 000.
- digits=015, penalty and sec_tick in the same cycle -> 004. At digits=007, penalty -> 000 with expired pulse (saturation).
- Count at 050, game_state=8'h40, 5 ticks -> stays 050. game_state=8'h10, 1 tick -> 049. game_state=8'h20 -> IDLE, digits hold 049, running=0.
- Assert reset mid-count at 073, asynchronously between clk edges -> digits=999, running=0 immediately. Release with game_state=8'h10 -> reload init_time.
- With COUNTDOWN_WARN_EN, WARN_THRESH=010: count 012 -> 011 -> 010 -> warn rises on the 010 cycle. Without the macro, warn stays 0 throughout.
